pipelined_signed_div_pow2: RTL and testbench



---
 rtl/pow2_div_pkg.sv | 57 +++++
 rtl/pipelined_signed_div_pow2_if.sv | 63 ++++++
 rtl/pow2_div_pipe_reg.sv | 53 +++++
 rtl/pipelined_signed_div_pow2.sv | 129 ++++++++++++
 tb/tb_pipelined_signed_div_pow2.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow2_div_pkg.sv
// -----------------------------------------------------------------------------
// pow2_div_pkg
//   Shared definitions for the pipelined signed divide-by-power-of-two block.
//
//   Contents:
//     div_mode_e - rounding mode encoding carried on up_mode.
//                  Code 3 is reserved and behaves like DIV_FLOOR.
//     bias_t     - wide container for the rounding bias. Callers truncate it
//                  to their own W+1 bits.
//     bias_f     - rounding bias added to the sign-extended dividend before
//                  the arithmetic right shift.
// -----------------------------------------------------------------------------
package pow2_div_pkg;

    typedef enum logic [1:0] {
        DIV_FLOOR = 2'd0,
        DIV_TRUNC = 2'd1,
        DIV_ROUND = 2'd2
    } div_mode_e;

    // Wide enough for any practical W; callers truncate to W+1 bits.
    localparam int BIAS_MAX_W = 64;
    typedef logic [BIAS_MAX_W-1:0] bias_t;

    // Bias for the requested mode.
    //   a_sign : sign bit of the dividend
    //   s      : shift amount (divisor 2^s)
    //   mode   : raw mode code; anything other than TRUNC/ROUND means floor
    //   w      : data width. s is clamped to w-1 so the bias always fits in
    //            w+1 bits.
    // Truncation adds 2^s-1 to negative dividends so the floor shift rounds
    // toward zero. Round-half-up adds half an LSB of the quotient.
    function automatic bias_t bias_f(input logic        a_sign,
                                     input int unsigned s,
                                     input logic [1:0]  mode,
                                     input int unsigned w);
        int unsigned sc;
        bias_t       b;
        sc = (s > w - 1) ? w - 1 : s;
        b  = '0;
        case (mode)
            DIV_TRUNC: begin
                if (a_sign) begin
                    b = (bias_t'(1) << sc) - bias_t'(1);
                end
            end
            DIV_ROUND: begin
                if (sc != 0) begin
                    b = bias_t'(1) << (sc - 1);
                end
            end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pipelined_signed_div_pow2_if.sv
// -----------------------------------------------------------------------------
// pipelined_signed_div_pow2_if
//   Stream bundle for the pipelined signed divide-by-power-of-two block.
//
//   Upstream (producer -> block):
//     up_vld, up_data (signed dividend), up_shift (divisor 2^s),
//     up_mode (0 floor, 1 truncate, 2 round half up, 3 = floor),
//     up_tag (opaque); up_rdy flows back.
//   Downstream (block -> consumer):
//     down_vld, down_quot, down_rem, down_tag; down_rdy flows back.
//
//   Modports:
//     slave  - the divider's view
//     master - the environment's view (drives up_*, down_rdy)
// -----------------------------------------------------------------------------
interface pipelined_signed_div_pow2_if #(
    parameter int W  = 8,
    parameter int SW = $clog2(W),
    parameter int TW = 4
);

    logic                up_vld;
    logic                up_rdy;
    logic signed [W-1:0] up_data;
    logic [SW-1:0]       up_shift;
    logic [1:0]          up_mode;
    logic [TW-1:0]       up_tag;

    logic                down_vld;
    logic                down_rdy;
    logic signed [W-1:0] down_quot;
    logic signed [W-1:0] down_rem;
    logic [TW-1:0]       down_tag;

    modport slave (
        input  up_vld,
        output up_rdy,
        input  up_data,
        input  up_shift,
        input  up_mode,
        input  up_tag,
        output down_vld,
        input  down_rdy,
        output down_quot,
        output down_rem,
        output down_tag
    );

    modport master (
        output up_vld,
        input  up_rdy,
        output up_data,
        output up_shift,
        output up_mode,
        output up_tag,
        input  down_vld,
        output down_rdy,
        input  down_quot,
        input  down_rem,
        input  down_tag
    );

endinterface

// File: rtl/pow2_div_pipe_reg.sv
// -----------------------------------------------------------------------------
// pow2_div_pipe_reg
//   One valid/ready pipeline register with full backpressure.
//
//   Ports:
//     clk, rst_n        - clock, asynchronous active-low reset
//     in_vld / in_rdy   - upstream handshake
//     in_data [PW]      - upstream payload
//     out_vld / out_rdy - downstream handshake
//     out_data [PW]     - registered payload, held while out_vld & !out_rdy
//
//   Only the valid flag is reset. The payload register is plain data.
//   in_rdy depends combinationally on out_rdy, so ready ripples back through
//   a chain of these in the same cycle. That lets a full pipe accept and
//   emit on the same edge.
// -----------------------------------------------------------------------------
module pow2_div_pipe_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [PW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [PW-1:0] out_data
);

    logic          vld_q;
    logic [PW-1:0] data_q;

    // Ready when empty, or when the held entry leaves this cycle.
    assign in_rdy = !vld_q || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (in_rdy) begin
            vld_q <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld && in_rdy) begin
            data_q <= in_data;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;

endmodule

// File: rtl/pipelined_signed_div_pow2.sv
// -----------------------------------------------------------------------------
// pipelined_signed_div_pow2
//   Two-stage pipelined signed divider by a run-time power of two.
//   Rounding modes: floor, truncate toward zero, round half up.
//   Also returns a remainder and passes an opaque tag through unchanged.
//
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset. Clears both stage valid flags
//             and discards any in-flight results.
//     bus   - pipelined_signed_div_pow2_if.slave
//             up_*   : dividend a, shift s, mode, tag, valid/ready
//             down_* : quotient q, remainder r = a - q*2^s, tag, valid/ready
//
//   Latency is 2 cycles from accept to down_vld. Throughput is one result
//   per cycle. The only combinational in-to-out path is down_rdy -> up_rdy.
// -----------------------------------------------------------------------------
module pipelined_signed_div_pow2
    import pow2_div_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W),
    parameter int TW = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_signed_div_pow2_if.slave    bus
);

    localparam int PW1 = (W + 1) + W + SW + TW;
    localparam int PW2 = W + W + TW;

    // When W is not a power of two, up_shift can encode values >= W.
    // Those are clamped to W-1.
    function automatic logic [SW-1:0] clamp_shift_f(input logic [SW-1:0] s);
        if (32'(s) >= 32'(W)) begin
            return SW'(W - 1);
        end
        return s;
    endfunction

    // Arithmetic shift of the biased sum. The result always fits in W bits
    // for s <= W-1, so dropping the extra sign bit is lossless.
    function automatic logic signed [W-1:0] quot_f(input logic signed [W:0] sum,
                                                   input logic [SW-1:0]     s);
        logic signed [W:0] sh;
        sh = sum >>> s;
        return sh[W-1:0];
    endfunction

    // r = a - q*2^s, evaluated in W+1 bits. The true remainder fits in W bits
    // in every mode.
    function automatic logic signed [W-1:0] rem_f(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] q,
                                                  input logic [SW-1:0]       s);
        logic signed [W:0] q_scaled;
        logic signed [W:0] diff;
        q_scaled = {q[W-1], q} << s;
        diff     = {a[W-1], a} - q_scaled;
        return diff[W-1:0];
    endfunction

    // ---- stage 0 -> 1: clamp shift, form biased sum --------------------------
    logic signed [W-1:0] a_p0;
    logic [SW-1:0]       s_p0;
    logic signed [W:0]   bias_p0;
    logic signed [W:0]   sum_p0;
    logic [PW1-1:0]      pl_p0;

    assign a_p0    = bus.up_data;
    assign s_p0    = clamp_shift_f(bus.up_shift);
    assign bias_p0 = (W + 1)'(bias_f(a_p0[W-1], 32'(s_p0), bus.up_mode, W));
    assign sum_p0  = {a_p0[W-1], a_p0} + bias_p0;
    assign pl_p0   = {sum_p0, a_p0, s_p0, bus.up_tag};

    logic           vld_p1;
    logic           rdy_p1;
    logic [PW1-1:0] pl_p1;

    pow2_div_pipe_reg #(
        .PW (PW1)
    ) u_stage1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (bus.up_vld),
        .in_rdy   (bus.up_rdy),
        .in_data  (pl_p0),
        .out_vld  (vld_p1),
        .out_rdy  (rdy_p1),
        .out_data (pl_p1)
    );

    // ---- stage 1 -> 2: shift for quotient, reconstruct remainder -------------
    logic signed [W:0]   sum_p1;
    logic signed [W-1:0] a_p1;
    logic [SW-1:0]       s_p1;
    logic [TW-1:0]       tag_p1;
    logic signed [W-1:0] quot_p1;
    logic signed [W-1:0] rem_p1;
    logic [PW2-1:0]      pl_p1_out;

    assign {sum_p1, a_p1, s_p1, tag_p1} = pl_p1;
    assign quot_p1   = quot_f(sum_p1, s_p1);
    assign rem_p1    = rem_f(a_p1, quot_p1, s_p1);
    assign pl_p1_out = {quot_p1, rem_p1, tag_p1};

    logic           vld_p2;
    logic [PW2-1:0] pl_p2;

    pow2_div_pipe_reg #(
        .PW (PW2)
    ) u_stage2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (vld_p1),
        .in_rdy   (rdy_p1),
        .in_data  (pl_p1_out),
        .out_vld  (vld_p2),
        .out_rdy  (bus.down_rdy),
        .out_data (pl_p2)
    );

    // ---- stage 2 output ------------------------------------------------------
    assign bus.down_vld  = vld_p2;
    assign bus.down_quot = pl_p2[PW2-1 -: W];
    assign bus.down_rem  = pl_p2[TW +: W];
    assign bus.down_tag  = pl_p2[TW-1:0];

endmodule

// File: tb/tb_pipelined_signed_div_pow2.sv
// -----------------------------------------------------------------------------
// tb_pipelined_signed_div_pow2
//   Self-checking bench for pipelined_signed_div_pow2 (W=8, TW=4).
//   Expected quotients and remainders come from directed constants or from an
//   integer-division reference model. The model uses floor, truncating and
//   round-half-up division on plain ints.
// -----------------------------------------------------------------------------
module tb_pipelined_signed_div_pow2;

    localparam int W  = 8;
    localparam int SW = $clog2(W);
    localparam int TW = 4;

    typedef struct {
        int a;
        int s;
        int m;
        int q;
        int r;
        int tag;
        int cyc;
    } item_t;

    logic clk;
    logic rst_n;

    pipelined_signed_div_pow2_if #(.W(W), .SW(SW), .TW(TW)) bus ();

    pipelined_signed_div_pow2 #(.W(W), .SW(SW), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int    errors  = 0;
    int    checks  = 0;
    int    cyc     = 0;
    int    emitted = 0;
    logic  lat_chk;
    item_t exp_q[$];

    logic               last_acc;
    logic               last_up_rdy;
    logic               last_dvld;
    logic signed [31:0] last_q;
    logic signed [31:0] last_r;
    logic signed [31:0] last_tag;

    // Directed vectors: a, s, mode, expected q, expected r
    int dir_a[20] = '{  -7,  -7,  -7,  -6,  -6,  -6, -128, -128, -128, 127,
                       127, 127, -128, 127,  -7,   5,   -7,  100, -100, -100};
    int dir_s[20] = '{   1,   1,   1,   2,   2,   2,    7,    7,    7,   7,
                         7,   7,    0,   0,   0,   0,    1,    3,    3,    3};
    int dir_m[20] = '{   0,   1,   2,   0,   1,   2,    0,    1,    2,   0,
                         1,   2,    0,   2,   1,   3,    3,    2,    1,    0};
    int dir_q[20] = '{  -4,  -3,  -3,  -2,  -1,  -1,   -1,   -1,   -1,   0,
                         0,   1, -128, 127,  -7,   5,   -4,   13,  -12,  -13};
    int dir_r[20] = '{   1,  -1,  -1,   2,  -2,  -2,    0,    0,    0, 127,
                       127,  -1,    0,   0,   0,   0,    1,   -4,   -4,    4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: divisor d = 2^s, integer arithmetic only.
    function automatic void ref_div(input int a, input int s, input int m,
                                    output int q, output int r);
        int sc;
        int d;
        sc = (s > W - 1) ? W - 1 : s;
        d  = 1 << sc;
        case (m)
            1:       q = a / d;
            2:       q = floor_div(a + d / 2, d);
            default: q = floor_div(a, d);
        endcase
        r = a - q * d;
    endfunction

    function automatic bit rem_in_range(input int a, input int s, input int m,
                                        input int r);
        int d;
        d = 1 << s;
        case (m)
            1:       return (a < 0) ? (r <= 0 && r > -d) : (r >= 0 && r < d);
            2:       return (s == 0) ? (r == 0) : (r >= -(d / 2) && r < d / 2);
            default: return (r >= 0 && r < d);
        endcase
    endfunction

    // One clock cycle: drive inputs after the edge, then sample the outputs
    // that will handshake on the next edge and score them.
    task automatic drive_cycle(input int vld, input int a, input int s, input int m,
                               input int tag, input int drdy, input int eq,
                               input int er, input int use_ref);
        item_t e;
        @(posedge clk);
        #1;
        cyc++;
        bus.up_vld   = (vld != 0);
        bus.up_data  = W'(a);
        bus.up_shift = SW'(s);
        bus.up_mode  = 2'(m);
        bus.up_tag   = TW'(tag);
        bus.down_rdy = (drdy != 0);
        #1;
        last_up_rdy = bus.up_rdy;
        last_dvld   = bus.down_vld;
        last_q      = 32'(bus.down_quot);
        last_r      = 32'(bus.down_rem);
        last_tag    = 32'(bus.down_tag);
        last_acc    = bus.up_vld && bus.up_rdy;
        if (bus.down_vld && bus.down_rdy) begin
            emitted++;
            chk("unexpected_out", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("quot", last_q, e.q);
                chk("rem", last_r, e.r);
                chk("tag", last_tag, e.tag);
                chk("identity", last_q * (1 << e.s) + last_r, e.a);
                chk("rem_range", 32'(rem_in_range(e.a, e.s, e.m, last_r)), 1);
                if (lat_chk) chk("latency", cyc - e.cyc, 2);
            end
        end
        if (last_acc) begin
            e.a   = a;
            e.s   = s;
            e.m   = m;
            e.tag = tag;
            e.cyc = cyc;
            if (use_ref != 0) begin
                ref_div(a, s, m, e.q, e.r);
            end else begin
                e.q = eq;
                e.r = er;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int drdy);
        drive_cycle(0, 0, 0, 0, 0, drdy, 0, 0, 1);
    endtask

    initial begin
        int k;
        int em0;
        int rnd_acc;
        int cycles;
        logic signed [31:0] hold_q;
        logic signed [31:0] hold_r;
        logic signed [31:0] hold_tag;

        bus.up_vld   = 1'b0;
        bus.up_data  = '0;
        bus.up_shift = '0;
        bus.up_mode  = '0;
        bus.up_tag   = '0;
        bus.down_rdy = 1'b0;
        lat_chk      = 1'b1;
        rst_n        = 1'b0;
        hold_q       = 0;
        hold_r       = 0;
        hold_tag     = 0;

        // Reset state
        #12;
        chk("reset_down_vld", 32'(bus.down_vld), 0);
        chk("reset_up_rdy", 32'(bus.up_rdy), 1);
        #10 rst_n = 1'b1;
        #1;
        chk("post_reset_down_vld", 32'(bus.down_vld), 0);
        chk("post_reset_up_rdy", 32'(bus.up_rdy), 1);

        // Directed vectors, back-to-back with down_rdy high
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1, dir_a[i], dir_s[i], dir_m[i], i % 16, 1,
                        dir_q[i], dir_r[i], 0);
            chk("dir_accept", 32'(last_acc), 1);
        end
        repeat (4) idle(1);
        chk("dir_drained", exp_q.size(), 0);

        // Backpressure: stall the consumer for 5 cycles while streaming
        lat_chk = 1'b0;
        k   = 0;
        em0 = emitted;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, k * 13 - 60, k % 8, k % 4, k, 0, 0, 0, 1);
            if (last_acc) k++;
            if (i == 2) begin
                hold_q   = last_q;
                hold_r   = last_r;
                hold_tag = last_tag;
            end
            if (i >= 2) begin
                chk("bp_up_rdy_low", 32'(last_up_rdy), 0);
                chk("bp_down_vld", 32'(last_dvld), 1);
            end
            if (i >= 3) begin
                chk("bp_hold_quot", last_q, hold_q);
                chk("bp_hold_rem", last_r, hold_r);
                chk("bp_hold_tag", last_tag, hold_tag);
            end
        end
        chk("bp_accepted", k, 2);
        for (int i = 0; i < 60 && (k < 10 || exp_q.size() > 0); i++) begin
            drive_cycle((k < 10) ? 1 : 0, k * 13 - 60, k % 8, k % 4, k, 1, 0, 0, 1);
            if (last_acc) k++;
        end
        chk("bp_all_accepted", k, 10);
        chk("bp_emitted", emitted - em0, 10);
        chk("bp_drained", exp_q.size(), 0);

        // Mid-stream asynchronous reset with two items in flight
        lat_chk = 1'b1;
        drive_cycle(1, 10, 1, 0, 1, 1, 0, 0, 1);
        drive_cycle(1, 20, 2, 1, 2, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        bus.up_vld = 1'b0;
        #1;
        chk("rst_pre_down_vld", 32'(bus.down_vld), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_down_vld", 32'(bus.down_vld), 0);
        chk("rst_async_up_rdy", 32'(bus.up_rdy), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_hold_down_vld", 32'(bus.down_vld), 0);
        #2;
        rst_n = 1'b1;
        drive_cycle(1, -50, 3, 2, 7, 1, 0, 0, 1);
        chk("rst_release_up_rdy", 32'(last_up_rdy), 1);
        chk("rst_release_accept", 32'(last_acc), 1);
        em0 = emitted;
        repeat (4) idle(1);
        chk("rst_new_emitted", emitted - em0, 1);
        chk("rst_drained", exp_q.size(), 0);

        // Random regression with random valid/ready
        lat_chk = 1'b0;
        rnd_acc = 0;
        cycles  = 0;
        while (rnd_acc < 10000 && cycles < 40000) begin
            drive_cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                        int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) != 0) ? 1 : 0,
                        0, 0, 1);
            if (last_acc) rnd_acc++;
            cycles++;
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        chk("rnd_accepted", rnd_acc, 10000);
        chk("rnd_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
